io_bus_arbiter: RTL and testbench

Parametrised, registered shared-bus interconnect between the J1 I/O port and N memory-mapped I/O slaves (USB SIE, board I/O, future peripherals). Each access is decoded on an address page field and routed to exactly one slave. A per-slave wait-state count stretches the access, and the CPU is stalled via `cpu_ready`. Accesses to unmapped pages complete with a fixed error value and are logged in a sticky error register.

---
 rtl/io_bus_arbiter.sv | 146 ++++++++++++++
 tb/tb_io_bus_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_arbiter.sv
// Registered shared-bus interconnect between the J1 I/O port and N slaves.
// Page-decoded select, per-slave wait states, sticky unmapped-access error.
module io_bus_arbiter #(
   parameter int N_SLAVES = 3,
   parameter int DW       = 16,
   parameter int AW       = 16,
   parameter int DEC_MSB  = 15,
   parameter int DEC_LSB  = 12,
   parameter logic [N_SLAVES*(DEC_MSB-DEC_LSB+1)-1:0] PAGE =
      {4'h2, 4'h1, 4'h0},
   parameter logic [N_SLAVES*3-1:0] WAIT = {3'd0, 3'd1, 3'd0},
   parameter logic [DW-1:0] ERR_VAL = 16'hDEAD
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [AW-1:0]          cpu_addr,
   input  logic [DW-1:0]          cpu_dout,
   input  logic                   cpu_rd,
   input  logic                   cpu_wr,
   output logic [DW-1:0]          cpu_din,
   output logic                   cpu_ready,
   output logic [AW-1:0]          s_addr,
   output logic [DW-1:0]          s_dout,
   output logic [N_SLAVES-1:0]    s_rd,
   output logic [N_SLAVES-1:0]    s_wr,
   input  logic [N_SLAVES*DW-1:0] s_din,
   input  logic                   err_clr,
   output logic                   err_flag,
   output logic [AW-1:0]          err_addr
);

   localparam int PW = DEC_MSB - DEC_LSB + 1;
   localparam int SW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [SW-1:0] sel;
   logic [SW-1:0] dec_sel;
   logic          dec_hit;
   logic [2:0]    dec_wait;
   logic          is_wr;
   logic          first;
   logic [2:0]    cnt;
   logic [DW-1:0] rdata;
   logic          req;
   logic          miss;

   assign req  = cpu_rd | cpu_wr;
   assign miss = (state == IDLE) && req && !dec_hit;

   // Scan from the top down so the lowest matching index wins.
   always_comb begin
      dec_hit  = 1'b0;
      dec_sel  = '0;
      dec_wait = '0;
      for (int i = N_SLAVES - 1; i >= 0; i--) begin
         if (cpu_addr[DEC_MSB:DEC_LSB] == PAGE[i*PW +: PW]) begin
            dec_hit  = 1'b1;
            dec_sel  = SW'(i);
            dec_wait = WAIT[i*3 +: 3];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (req) state_nx = dec_hit ? ACCESS : DONE;
         ACCESS:  if (cnt == 3'd0) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_addr <= '0;
         s_dout <= '0;
         sel    <= '0;
         is_wr  <= 1'b0;
         first  <= 1'b0;
         cnt    <= '0;
         rdata  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req) begin
                  s_addr <= cpu_addr;
                  s_dout <= cpu_dout;
                  is_wr  <= cpu_wr;
                  sel    <= dec_sel;
                  cnt    <= dec_wait;
                  first  <= 1'b1;
                  if (!dec_hit) rdata <= ERR_VAL;
               end
            end
            ACCESS: begin
               first <= 1'b0;
               if (cnt != 3'd0) cnt <= cnt - 3'd1;
               else if (!is_wr) rdata <= s_din[sel*DW +: DW];
            end
            default: ;
         endcase
      end
   end

   // A new error beats a same-cycle clear and reloads the address.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_flag <= 1'b0;
         err_addr <= '0;
      end else if (miss) begin
         err_flag <= 1'b1;
         if (!err_flag || err_clr) err_addr <= cpu_addr;
      end else if (err_clr) begin
         err_flag <= 1'b0;
      end
   end

   always_comb begin
      s_rd = '0;
      s_wr = '0;
      if (state == ACCESS) begin
         if (is_wr) begin
            if (first) s_wr = N_SLAVES'(1) << sel;
         end else begin
            s_rd = N_SLAVES'(1) << sel;
         end
      end
   end

   assign cpu_ready = (state == DONE);
   assign cpu_din   = rdata;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: decode, wait states, errors, reset.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_io_bus_arbiter;

   logic        clk;
   logic        reset;
   logic [15:0] cpu_addr;
   logic [15:0] cpu_dout;
   logic        cpu_rd;
   logic        cpu_wr;
   logic [15:0] cpu_din;
   logic        cpu_ready;
   logic [15:0] s_addr;
   logic [15:0] s_dout;
   logic [2:0]  s_rd;
   logic [2:0]  s_wr;
   logic [47:0] s_din;
   logic        err_clr;
   logic        err_flag;
   logic [15:0] err_addr;

   int n_cmp;
   int n_err;

   io_bus_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_addr  (cpu_addr),
      .cpu_dout  (cpu_dout),
      .cpu_rd    (cpu_rd),
      .cpu_wr    (cpu_wr),
      .cpu_din   (cpu_din),
      .cpu_ready (cpu_ready),
      .s_addr    (s_addr),
      .s_dout    (s_dout),
      .s_rd      (s_rd),
      .s_wr      (s_wr),
      .s_din     (s_din),
      .err_clr   (err_clr),
      .err_flag  (err_flag),
      .err_addr  (err_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      reset    = 1'b1;
      cpu_addr = '0;
      cpu_dout = '0;
      cpu_rd   = 1'b0;
      cpu_wr   = 1'b0;
      err_clr  = 1'b0;
      s_din    = {16'h9ABC, 16'h5678, 16'h1234};

      step();
      chk("rst_ready", 32'(cpu_ready), 32'h0);
      chk("rst_din", 32'(cpu_din), 32'h0);
      chk("rst_srd", 32'(s_rd), 32'h0);
      chk("rst_swr", 32'(s_wr), 32'h0);
      chk("rst_saddr", 32'(s_addr), 32'h0);
      chk("rst_sdout", 32'(s_dout), 32'h0);
      chk("rst_eflag", 32'(err_flag), 32'h0);
      chk("rst_eaddr", 32'(err_addr), 32'h0);
      reset = 1'b0;
      step();

      // read slave 0, no wait states
      cpu_addr = 16'h0004;
      cpu_rd   = 1'b1;
      step();
      chk("r0_srd", 32'(s_rd), 32'h1);
      chk("r0_swr", 32'(s_wr), 32'h0);
      chk("r0_nrdy", 32'(cpu_ready), 32'h0);
      chk("r0_saddr", 32'(s_addr), 32'h0004);
      step();
      chk("r0_rdy", 32'(cpu_ready), 32'h1);
      chk("r0_din", 32'(cpu_din), 32'h1234);
      chk("r0_srd_off", 32'(s_rd), 32'h0);
      cpu_rd = 1'b0;
      step();
      chk("r0_idle", 32'(cpu_ready), 32'h0);

      // write slave 1, one wait state; request dropped mid-access
      cpu_addr = 16'h1010;
      cpu_dout = 16'hA5A5;
      cpu_wr   = 1'b1;
      step();
      chk("w1_swr", 32'(s_wr), 32'h2);
      chk("w1_srd", 32'(s_rd), 32'h0);
      chk("w1_sdout", 32'(s_dout), 32'hA5A5);
      chk("w1_nrdy1", 32'(cpu_ready), 32'h0);
      cpu_wr   = 1'b0;
      cpu_dout = 16'h0000;
      step();
      chk("w1_swr_once", 32'(s_wr), 32'h0);
      chk("w1_sdout2", 32'(s_dout), 32'hA5A5);
      chk("w1_nrdy2", 32'(cpu_ready), 32'h0);
      step();
      chk("w1_rdy", 32'(cpu_ready), 32'h1);
      chk("w1_sdout3", 32'(s_dout), 32'hA5A5);
      chk("w1_saddr", 32'(s_addr), 32'h1010);
      step();
      chk("w1_idle", 32'(cpu_ready), 32'h0);

      // unmapped read
      cpu_addr = 16'hF000;
      cpu_rd   = 1'b1;
      step();
      chk("m1_rdy", 32'(cpu_ready), 32'h1);
      chk("m1_din", 32'(cpu_din), 32'hDEAD);
      chk("m1_eflag", 32'(err_flag), 32'h1);
      chk("m1_eaddr", 32'(err_addr), 32'hF000);
      chk("m1_srd", 32'(s_rd), 32'h0);
      cpu_rd = 1'b0;
      step();
      cpu_addr = 16'hE000;
      cpu_rd   = 1'b1;
      step();
      chk("m2_rdy", 32'(cpu_ready), 32'h1);
      chk("m2_eaddr", 32'(err_addr), 32'hF000);
      cpu_rd = 1'b0;
      step();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("clr_eflag", 32'(err_flag), 32'h0);
      chk("clr_eaddr", 32'(err_addr), 32'hF000);

      // clear and new miss in the same cycle
      cpu_addr = 16'hB000;
      cpu_wr   = 1'b1;
      step();
      chk("m3_eaddr", 32'(err_addr), 32'hB000);
      cpu_wr = 1'b0;
      step();
      cpu_addr = 16'hC000;
      cpu_rd   = 1'b1;
      err_clr  = 1'b1;
      step();
      chk("m4_eflag", 32'(err_flag), 32'h1);
      chk("m4_eaddr", 32'(err_addr), 32'hC000);
      chk("m4_rdy", 32'(cpu_ready), 32'h1);
      cpu_rd  = 1'b0;
      err_clr = 1'b0;
      step();

      // read and write together: write wins
      cpu_addr = 16'h2000;
      cpu_dout = 16'h0F0F;
      cpu_rd   = 1'b1;
      cpu_wr   = 1'b1;
      step();
      chk("rw_swr", 32'(s_wr), 32'h4);
      chk("rw_srd", 32'(s_rd), 32'h0);
      step();
      chk("rw_rdy", 32'(cpu_ready), 32'h1);
      chk("rw_srd2", 32'(s_rd), 32'h0);
      chk("rw_swr2", 32'(s_wr), 32'h0);
      cpu_rd = 1'b0;
      cpu_wr = 1'b0;
      step();

      // reset during ACCESS of a one-wait read
      cpu_addr = 16'h1000;
      cpu_rd   = 1'b1;
      step();
      chk("ra_srd", 32'(s_rd), 32'h2);
      #1 reset = 1'b1;
      #1;
      chk("ra_srd_async", 32'(s_rd), 32'h0);
      chk("ra_eflag", 32'(err_flag), 32'h0);
      step();
      chk("ra_nrdy", 32'(cpu_ready), 32'h0);
      reset  = 1'b0;
      cpu_rd = 1'b0;
      step();
      chk("ra_nrdy2", 32'(cpu_ready), 32'h0);

      // fresh read after reset, standard latency
      cpu_addr = 16'h1000;
      cpu_rd   = 1'b1;
      step();
      chk("rb_srd1", 32'(s_rd), 32'h2);
      chk("rb_nrdy1", 32'(cpu_ready), 32'h0);
      step();
      chk("rb_srd2", 32'(s_rd), 32'h2);
      chk("rb_nrdy2", 32'(cpu_ready), 32'h0);
      step();
      chk("rb_rdy", 32'(cpu_ready), 32'h1);
      chk("rb_din", 32'(cpu_din), 32'h5678);
      cpu_rd = 1'b0;
      step();
      chk("rb_idle", 32'(cpu_ready), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
